// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//
// Immediate extension stage with a 2-entry elastic output FIFO.
// Each accepted immediate is extended once, on the input side, according to
// its mode. The result is then stored and presented in acceptance order.
//
// Modes:
//   00 sign-extend
//   01 zero-extend
//   10 upper placement (low bits zero)
//   11 branch (sign-extend, then shift left by 2)
//
// Parameters:
//   IN_W   immediate width, legal range 2..30
//   OUT_W  extended width, must be >= IN_W+2
//
// Optional feature (macro IMM_EXT_CNT_EN):
//   Adds the xfer_cnt output, a saturating count of output transfers.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream offers instr/mode
//   in_ready   FIFO not full (decoded from the registered count only)
//   instr      raw immediate field
//   mode       extension mode
//   out_valid  FIFO not empty
//   out_ready  downstream accepts the head entry
//   SEout      extended immediate at the FIFO head (zero when empty)
//   xfer_cnt   output transfer count (only with IMM_EXT_CNT_EN)
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  instr,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] SEout
`ifdef IMM_EXT_CNT_EN
    ,
    output logic [15:0]      xfer_cnt
`endif
);

    localparam int PAD_W = OUT_W - IN_W;

    // Reject illegal parameter combinations at elaboration time.
    generate
        if ((IN_W < 2) || (IN_W > 30)) begin : g_bad_in_w
            $error("imm_extend_pipe: IN_W out of range 2..30");
        end
        if (OUT_W < IN_W + 2) begin : g_bad_out_w
            $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
        end
    endgenerate

    // Extension of one immediate according to its mode.
    function automatic logic [OUT_W-1:0] extend_imm(
        input logic [IN_W-1:0] imm,
        input logic [1:0]      md
    );
        logic [OUT_W-1:0] sx;
        logic [OUT_W-1:0] res;
        sx = {{PAD_W{imm[IN_W-1]}}, imm};
        case (md)
            2'b00:   res = sx;
            2'b01:   res = {{PAD_W{1'b0}}, imm};
            2'b10:   res = {imm, {PAD_W{1'b0}}};
            2'b11:   res = {sx[OUT_W-3:0], 2'b00};
            default: res = sx;
        endcase
        return res;
    endfunction

    logic [OUT_W-1:0] mem_r [0:1];
    logic             head_r;
    logic             tail_r;
    logic [1:0]       count_r;
    logic [1:0]       count_nxt_s;
    logic             push_s;
    logic             pop_s;
    logic [OUT_W-1:0] ext_s;

    // Handshake decode and input-side extension.
    always_comb begin
        in_ready  = (count_r != 2'd2);
        out_valid = (count_r != 2'd0);
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
        ext_s     = extend_imm(instr, mode);
    end

    // Head entry drives the output. It is forced to zero when the FIFO is empty.
    always_comb begin
        if (out_valid) begin
            SEout = mem_r[head_r];
        end else begin
            SEout = {OUT_W{1'b0}};
        end
    end

    // Next occupancy. Simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= {OUT_W{1'b0}};
            mem_r[1] <= {OUT_W{1'b0}};
            head_r   <= 1'b0;
            tail_r   <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[tail_r] <= ext_s;
                tail_r        <= ~tail_r;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end
            count_r <= count_nxt_s;
        end
    end

`ifdef IMM_EXT_CNT_EN
    logic [15:0] xfer_cnt_r;

    // Saturating count of output transfers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_r <= 16'h0000;
        end else if (pop_s && (xfer_cnt_r != 16'hFFFF)) begin
            xfer_cnt_r <= xfer_cnt_r + 16'h0001;
        end else begin
            xfer_cnt_r <= xfer_cnt_r;
        end
    end

    assign xfer_cnt = xfer_cnt_r;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SEout;
`ifdef IMM_EXT_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    int tests;
    int fails;
    logic [31:0] model_q [$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SEout     (SEout)
`ifdef IMM_EXT_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Extension computed arithmetically: signed value, scaling, truncation to 32 bits.
    function automatic logic [31:0] model_ext(input int unsigned v, input int md);
        longint s;
        longint r;
        s = (v >= 32768) ? (longint'(v) - 65536) : longint'(v);
        case (md)
            0:       r = s;
            1:       r = longint'(v);
            2:       r = longint'(v) * 65536;
            default: r = s * 4;
        endcase
        return r[31:0];
    endfunction

    // Scoreboard: record accepted inputs and check every popped output.
    always @(posedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (model_q.size() == 0) begin
                    chk("pop_underflow", 64'd1, 64'd0);
                end else begin
                    chk("pop_order", SEout, model_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                model_q.push_back(model_ext(instr, mode));
            end
        end
    end

    // Per-cycle comparison of the flow-control outputs and the head value.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_SEout", SEout, 32'h0);
            chk("rst_in_ready", in_ready, 1'b1);
        end else begin
            chk("cyc_out_valid", out_valid, model_q.size() != 0);
            chk("cyc_in_ready", in_ready, model_q.size() != 2);
            if (model_q.size() != 0) begin
                chk("cyc_SEout", SEout, model_q[0]);
            end
        end
    end

    task automatic push(input logic [15:0] v, input logic [1:0] m);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = v;
        mode     = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] lit_exp [4];
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = 16'h0;
        mode      = 2'b00;
        out_ready = 1'b0;
        #3;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_SEout", SEout, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Model pinned against hand-computed values.
        chk("model_m00", model_ext(32'h8004, 0), 32'hFFFF8004);
        chk("model_m11", model_ext(32'h8004, 3), 32'hFFFE0010);

        // Single transfers in each mode with out_ready high.
        lit_exp[0] = 32'hFFFF8004;
        lit_exp[1] = 32'h00008004;
        lit_exp[2] = 32'h80040000;
        lit_exp[3] = 32'hFFFE0010;
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            push(16'h8004, 2'(m));
            chk("mode_SEout", SEout, lit_exp[m]);
            chk("mode_valid", out_valid, 1'b1);
            @(posedge clk);
            #1;
            chk("mode_one_cycle", out_valid, 1'b0);
        end
        push(16'h7FFF, 2'b11);
        chk("branch_pos", SEout, 32'h0001FFFC);
        idle(1);

        // Fill while stalled, third offer refused, then drain in order.
        out_ready = 1'b0;
        push(16'h0001, 2'b01);
        push(16'h0002, 2'b01);
        chk("full_in_ready", in_ready, 1'b0);
        push(16'h0003, 2'b01);
        chk("full_hold_SEout", SEout, 32'h1);
        chk("full_still_full", in_ready, 1'b0);
        idle(2);
        chk("stall_stable", SEout, 32'h1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_second", SEout, 32'h2);
        chk("drain_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("drain_empty", out_valid, 1'b0);

        // Streaming at occupancy 1: push and pop on every edge.
        out_ready = 1'b0;
        push(16'd100, 2'b01);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            instr     = 16'(101 + i);
            mode      = 2'b01;
            @(posedge clk);
            #1;
            chk("stream_in_ready", in_ready, 1'b1);
            chk("stream_SEout", SEout, 32'(101 + i));
        end
        in_valid = 1'b0;
        idle(2);
        chk("stream_drained", out_valid, 1'b0);

        // Asynchronous reset with two stored entries.
        out_ready = 1'b0;
        push(16'h00AA, 2'b00);
        push(16'h00BB, 2'b00);
        #2;
        rst_n = 1'b0;
        model_q.delete();
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_SEout", SEout, 32'h0);
        chk("async_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_empty", out_valid, 1'b0);
        out_ready = 1'b1;
        push(16'h0007, 2'b01);
        chk("post_rst_first", SEout, 32'h7);
        idle(1);

        // Mixed traffic with varying backpressure.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = 16'($urandom);
            mode      = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(3);
        chk("mixed_drained", model_q.size(), 0);

`ifdef IMM_EXT_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        model_q.delete();
        #1;
        chk("cnt_reset", xfer_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push(16'h0010, 2'b01);
        idle(1);
        chk("cnt_one", xfer_cnt, 16'h1);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        mode      = 2'b01;
        for (int i = 0; i < 65540; i++) begin
            instr = 16'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        idle(3);
        chk("cnt_saturate", xfer_cnt, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        model_q.delete();
        #1;
        chk("cnt_cleared", xfer_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width; legal range 2..30.
REQ-002 Parameter OUT_W, default 32, extended output width; SHALL satisfy OUT_W >= IN_W+2, otherwise elaboration fails.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream offers instr/mode this cycle.
REQ-006 in_ready  output  1  block can accept; transfer when in_valid && in_ready at rising edge.
REQ-007 instr  input  IN_W  raw immediate field.
REQ-008 mode  input  2  extension mode: 00 sign, 01 zero, 10 upper, 11 branch.
REQ-009 out_valid  output  1  SEout holds a valid result.
REQ-010 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready at rising edge.
REQ-011 SEout  output  OUT_W  extended immediate at FIFO head.
REQ-012 xfer_cnt  output  16  output transfer count; present only with IMM_EXT_CNT_EN.

Function
REQ-013 Mode 00: SEout = instr sign-extended to OUT_W (bit IN_W-1 replicated).
REQ-014 Mode 01: SEout = instr zero-extended to OUT_W.
REQ-015 Mode 10: SEout = instr placed in bits OUT_W-1..OUT_W-IN_W, low OUT_W-IN_W bits zero.
REQ-016 Mode 11: SEout = (instr sign-extended to OUT_W) shifted left 2, two LSBs zero; bits shifted out discarded.
REQ-017 Extension computed on the input side and stored; stored results never recomputed from later mode/instr.
REQ-018 Storage: 2-entry FIFO, occupancy count 0..2, registered head/tail pointers wrapping 1->0.
REQ-019 in_ready = (count != 2), combinational from registered count only; no path from out_ready to in_ready.
REQ-020 out_valid = (count != 0); SEout = head entry; both from registers only.
REQ-021 Latency: value accepted at edge N visible on SEout with out_valid=1 after edge N when count was 0.
REQ-022 Push only: count+1; pop only: count-1; push and pop same edge: count unchanged, head and tail both advance.
REQ-023 count==2: in_ready=0, in_valid ignored; pop that edge makes in_ready=1 after the edge.
REQ-024 count==0 with out_ready=1: no pop, no state change.
REQ-025 Order preserved: outputs emerge in exact acceptance order, no drops, no duplicates.
REQ-026 While out_valid=1 and out_ready=0, SEout SHALL hold stable.

Reset
REQ-027 rst_n low: count=0, pointers=0, out_valid=0, SEout=0, in_ready=1, xfer_cnt=0, effective immediately (asynchronous).
REQ-028 Reset mid-operation discards all stored entries; first transfer after release behaves as from empty.
REQ-029 Release of rst_n is synchronous to clk by the integrator; the block adds no synchroniser.

Configuration
REQ-030 Macro IMM_EXT_CNT_EN defined: xfer_cnt port exists, increments by 1 on each output transfer, saturates at 16'hFFFF, cleared only by reset.
REQ-031 Macro IMM_EXT_CNT_EN undefined: no xfer_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-032 Defaults, mode 00, instr 16'h8004, out_ready=1 -> next cycle SEout 32'hFFFF8004, out_valid=1 for one cycle.
REQ-033 Modes 01/10/11 with instr 16'h8004 -> SEout 32'h00008004 / 32'h80040000 / 32'hFFFE0010.
REQ-034 out_ready=0, push 16'h0001 then 16'h0002 -> in_ready=0 after 2nd edge; third offer 16'h0003 not accepted; raise out_ready -> outputs 1,2 in order, then in_ready=1.
REQ-035 count=1, simultaneous push and pop for 10 cycles of incrementing instr -> count stays 1, in_ready=1, outputs contiguous, none lost.
REQ-036 Two entries stored, assert rst_n=0 mid-cycle -> out_valid=0, SEout=0, in_ready=1 immediately, no stale entry after release.
REQ-037 IMM_EXT_CNT_EN defined, 65540 output transfers -> xfer_cnt reads 16'hFFFF; reset -> 0.
